// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter. Sends one byte (8 data bits,
// odd parity, stop) over the open-drain clock/data pair and checks the
// device ACK. Optional watchdog: define PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe
);

  // state     | meaning
  // IDLE      | lines released, waiting for tx_valid
  // INHIBIT   | clock held low for INHIBIT_CYCLES
  // REQ       | clock and data low (start bit), one cycle
  // XFER      | device-clocked: 8 data bits, parity, stop
  // ACK       | sample device ACK on the next falling edge
  // WAIT_IDLE | wait for both lines high two cycles in a row
  // DONE      | tx_done (and tx_error) pulse
  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_XFER, S_ACK, S_WAIT_IDLE, S_DONE
  } state_t;

  localparam int unsigned IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LOAD = IW'(INHIBIT_CYCLES - 1);

  state_t      state, state_n;
  logic [IW-1:0] inh_cnt, inh_cnt_n;
  logic [8:0]  shift, shift_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic        data_oe_q, data_oe_n;
  logic        err_q, err_n;
  logic        idle_seen, idle_seen_n;
  logic        clk_meta, sync_clk, clk_prev;
  logic        data_meta, sync_data;
  logic        fe;
  logic        timeout_hit;

  // Two-flop synchronisers plus a delayed copy of the clock for edge detect.
  // Reset to the idle-high bus level so no edge is seen leaving reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_meta  <= 1'b1;
      sync_clk  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      sync_data <= 1'b1;
    end else begin
      clk_meta  <= ps2_clock_in;
      sync_clk  <= clk_meta;
      clk_prev  <= sync_clk;
      data_meta <= ps2_data_in;
      sync_data <= data_meta;
    end
  end

  assign fe = clk_prev & ~sync_clk;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] WD_LOAD = WW'(TIMEOUT_CYCLES - 1);

  logic [WW-1:0] wd_cnt;
  logic          wd_active;

  assign wd_active   = (state == S_REQ) || (state == S_XFER) ||
                       (state == S_ACK) || (state == S_WAIT_IDLE);
  assign timeout_hit = wd_active && (wd_cnt == '0) && !fe;

  // Watchdog: held at its load value outside the device-paced states,
  // reloaded by every falling PS/2 clock edge, otherwise counts down.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      wd_cnt <= '0;
    else if (!wd_active || fe)
      wd_cnt <= WD_LOAD;
    else if (wd_cnt != '0)
      wd_cnt <= wd_cnt - WW'(1);
  end
`else
  // No watchdog in this build; the parameter only keeps the interface uniform.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // FSM and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      inh_cnt   <= '0;
      shift     <= '0;
      bit_cnt   <= '0;
      data_oe_q <= 1'b0;
      err_q     <= 1'b0;
      idle_seen <= 1'b0;
    end else begin
      state     <= state_n;
      inh_cnt   <= inh_cnt_n;
      shift     <= shift_n;
      bit_cnt   <= bit_cnt_n;
      data_oe_q <= data_oe_n;
      err_q     <= err_n;
      idle_seen <= idle_seen_n;
    end
  end

  // Next-state, datapath updates and state-decoded outputs.
  always_comb begin
    state_n      = state;
    inh_cnt_n    = inh_cnt;
    shift_n      = shift;
    bit_cnt_n    = bit_cnt;
    data_oe_n    = data_oe_q;
    err_n        = err_q;
    idle_seen_n  = 1'b0;
    tx_ready     = 1'b0;
    busy         = 1'b1;
    tx_done      = 1'b0;
    tx_error     = 1'b0;
    ps2_clock_oe = 1'b0;
    case (state)
      S_IDLE: begin
        tx_ready  = 1'b1;
        busy      = 1'b0;
        data_oe_n = 1'b0;
        if (tx_valid) begin
          state_n   = S_INHIBIT;
          inh_cnt_n = INH_LOAD;
          shift_n   = {~^tx_data, tx_data};
          bit_cnt_n = '0;
          err_n     = 1'b0;
        end
      end
      S_INHIBIT: begin
        ps2_clock_oe = 1'b1;
        if (inh_cnt == '0) begin
          state_n   = S_REQ;
          data_oe_n = 1'b1;
        end else begin
          inh_cnt_n = inh_cnt - IW'(1);
        end
      end
      S_REQ: begin
        ps2_clock_oe = 1'b1;
        state_n      = S_XFER;
        bit_cnt_n    = '0;
      end
      S_XFER: begin
        if (fe) begin
          if (bit_cnt == 4'd9) begin
            data_oe_n = 1'b0;
            state_n   = S_ACK;
          end else begin
            data_oe_n = ~shift[0];
            shift_n   = {1'b0, shift[8:1]};
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
      end
      S_ACK: begin
        if (fe) begin
          err_n   = sync_data;
          state_n = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (sync_clk && sync_data) begin
          idle_seen_n = 1'b1;
          if (idle_seen)
            state_n = S_DONE;
        end
      end
      S_DONE: begin
        tx_done  = 1'b1;
        tx_error = err_q;
        state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (timeout_hit) begin
      state_n   = S_DONE;
      data_oe_n = 1'b0;
      err_n     = 1'b1;
    end
  end

  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host,
// a scoreboard queue holds the expected frame/error per transfer and a
// monitor checks them whenever tx_done pulses.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int unsigned INH  = 10;
  localparam int unsigned TMO  = 200;
  localparam int HALF          = 8;
  localparam int MODE_ACK      = 0;
  localparam int MODE_NACK     = 1;
  localparam int MODE_SILENT   = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, tx_done, tx_error;
  logic       ps2_clock_in, ps2_data_in, ps2_clock_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  // Open-drain wired-AND of host and device.
  assign ps2_clock_in = dev_clk & ~ps2_clock_oe;
  assign ps2_data_in  = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .busy(busy), .tx_done(tx_done), .tx_error(tx_error),
    .ps2_clock_in(ps2_clock_in), .ps2_data_in(ps2_data_in),
    .ps2_clock_oe(ps2_clock_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] frame;
    logic       err;
    bit         chk_frame;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         req_cyc = 0;
  int         done_cyc = 0;
  int         dev_mode = MODE_ACK;
  int         dev_edges = 0;
  logic [9:0] dev_last = '0;
  bit         dev_got = 1'b0;
  bit         post = 1'b0;
  int         inh_len = 0;
  int         req_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic dev_wait(input int n, inout bit ab);
    for (int i = 0; i < n && !ab; i++) begin
      @(negedge clock);
      if (reset) ab = 1'b1;
    end
  endtask

  // Device model: clocks 11 falling edges, samples the line at the end of
  // each low phase, and drives ACK low before edge 11 unless told not to.
  task automatic dev_frame();
    bit ab = 1'b0;
    logic [9:0] cap = '0;
    dev_edges = 0;
    dev_wait(HALF, ab);
    for (int k = 1; k <= 11 && !ab; k++) begin
      if (k == 11 && dev_mode == MODE_ACK) begin
        dev_data = 1'b0;
        dev_wait(2, ab);
      end
      dev_clk = 1'b0;
      dev_edges = k;
      dev_wait(HALF, ab);
      if (k <= 10) cap[k-1] = ps2_data_in;
      if (k == 10 && !ab) begin
        dev_last = cap;
        dev_got  = 1'b1;
      end
      dev_clk = 1'b1;
      dev_wait(HALF, ab);
    end
    dev_clk  = 1'b1;
    dev_data = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (!reset && ps2_clock_oe && ps2_data_oe && dev_mode != MODE_SILENT)
        dev_frame();
    end
  end

  // Inhibit / request-phase monitor.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        inh_len = 0;
        req_len = 0;
      end else if (ps2_clock_oe && !ps2_data_oe) begin
        inh_len++;
      end else if (ps2_clock_oe && ps2_data_oe) begin
        if (req_len == 0) begin
          check("inhibit_len", inh_len, INH);
          req_cyc = cyc;
        end
        req_len++;
      end else begin
        if (req_len != 0) check("req_len", req_len, 1);
        inh_len = 0;
        req_len = 0;
      end
    end
  end

  // Scoreboard monitor: pops an expectation on every tx_done.
  initial begin
    forever begin
      @(negedge clock);
      if (post) begin
        check("done_width", tx_done, 0);
        check("error_width", tx_error, 0);
        check("ready_after_done", tx_ready, 1);
        check("busy_after_done", busy, 0);
        post = 1'b0;
      end else if (tx_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got tx_done=1, expected no transfer pending");
        end else begin
          e = exp_q.pop_front();
          check("tx_error", tx_error, e.err);
          if (e.chk_frame) begin
            check("frame_captured", dev_got, 1);
            check("frame_bits", dev_last, e.frame);
          end
        end
        check("clock_oe_at_done", ps2_clock_oe, 0);
        check("data_oe_at_done", ps2_data_oe, 0);
        check("busy_at_done", busy, 1);
        dev_got = 1'b0;
        post = 1'b1;
      end
    end
  end

  task automatic push(input logic [9:0] frame, input logic err, input bit chk);
    exp_t x;
    x.frame = frame;
    x.err = err;
    x.chk_frame = chk;
    exp_q.push_back(x);
  endtask

  task automatic send(input logic [7:0] d);
    int n = 0;
    @(negedge clock);
    while (!tx_ready && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (!tx_ready) begin
      checks++;
      errors++;
      $display("FAIL send_ready_timeout: got tx_ready=0, expected 1");
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (done_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d done pulses, expected %0d", done_cnt, target);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic wait_edges(input int k);
    int n = 0;
    while (dev_edges != k && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (dev_edges != k) begin
      checks++;
      errors++;
      $display("FAIL edge_timeout: got edge %0d, expected %0d", dev_edges, k);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish before 500 us");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clock);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_tx_error", tx_error, 0);
    check("rst_clock_oe", ps2_clock_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // {stop, parity, data} as seen on the line, LSB first
    push(10'b11_1110_1101, 1'b0, 1'b1);   // 0xED, parity 1
    send(8'hED);
    wait_done(1);
    push(10'b10_0000_0111, 1'b0, 1'b1);   // 0x07, parity 0
    send(8'h07);
    wait_done(2);
    push(10'b11_0000_0000, 1'b0, 1'b1);   // 0x00, parity 1
    send(8'h00);
    wait_done(3);

    dev_mode = MODE_NACK;
    push(10'b10_1010_1011, 1'b1, 1'b1);   // 0xAB, no ACK
    send(8'hAB);
    wait_done(4);
    dev_mode = MODE_ACK;

    // A request while busy must be dropped.
    push(10'b11_1110_1101, 1'b0, 1'b1);
    send(8'hED);
    wait_edges(2);
    @(negedge clock);
    tx_data  = 8'h12;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    wait_done(5);
    repeat (60) @(negedge clock);
    check("ignored_busy", busy, 0);
    check("ignored_done_count", done_cnt, 5);

    // Reset mid-frame: 0x55 bit 3 is 0, so data is pulled low after edge 4.
    send(8'h55);
    wait_edges(4);
    repeat (6) @(negedge clock);
    check("pre_reset_data_oe", ps2_data_oe, 1);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("midrst_clock_oe", ps2_clock_oe, 0);
    check("midrst_data_oe", ps2_data_oe, 0);
    check("midrst_tx_ready", tx_ready, 1);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    push(10'b10_1111_0100, 1'b0, 1'b1);   // 0xF4, parity 0
    send(8'hF4);
    wait_done(6);

    dev_mode = MODE_SILENT;
`ifdef PS2_TX_TIMEOUT_EN
    push(10'b00_0000_0000, 1'b1, 1'b0);
    send(8'hA5);
    wait_done(7);
    check("timeout_latency", done_cyc - req_cyc, TMO);
`else
    send(8'hA5);
    repeat (400) @(negedge clock);
    check("silent_busy", busy, 1);
    check("silent_done_count", done_cnt, 6);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("silent_rst_busy", busy, 0);
    reset = 1'b0;
`endif

    repeat (5) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
